// File: rtl/fxp_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fxp_div_seq: sequential restoring UQ(W-F).F divider, one bit per clock.   |
// | Define FXDIV_ROUND_EN for round-half-up via a guard iteration.  Rev 1.0   |
// +--------------------------------------------------------------------------+
module fxp_div_seq #(
  parameter int W = 10,
  parameter int F = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic         ov,
  output logic         dz
);

`ifdef FXDIV_ROUND_EN
  localparam int c_niter = W + F + 1;
  localparam int c_qw    = W + 1;
`else
  localparam int c_niter = W + F;
  localparam int c_qw    = W;
`endif
  localparam int            c_cw   = $clog2(c_niter + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(c_niter - 1);
  localparam logic [c_cw-1:0] c_frac = c_cw'(F);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [W-1:0]      b_q;
  logic [W+F-1:0]    d_q;
  logic [W:0]        r_q;
  logic [c_qw-2:0]   quo_q;
  logic [c_cw-1:0]   cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [W-1:0]      q_q;
  logic              ov_q;
  logic              dz_q;

  logic [W+1:0]      w_r_shift;
  logic [W+1:0]      w_diff;
  logic              w_bit;
  logic [W:0]        r_d;
  logic [c_qw-1:0]   quo_d;
  logic [W-1:0]      w_res;
  logic              w_res_ov;

  // A clear borrow out of the wide subtraction means R >= B.
  always_comb begin
    w_r_shift = {r_q, d_q[W+F-1]};
    w_diff    = w_r_shift - {2'b00, b_q};
    w_bit     = ~w_diff[W+1];
    r_d       = w_bit ? w_diff[W:0] : w_r_shift[W:0];
    quo_d     = {quo_q, w_bit};
  end

`ifdef FXDIV_ROUND_EN
  logic [W:0] w_rnd;
  always_comb begin
    w_rnd    = {1'b0, quo_d[W:1]} + {{W{1'b0}}, quo_d[0]};
    w_res_ov = w_rnd[W];
    w_res    = w_rnd[W] ? {W{1'b1}} : w_rnd[W-1:0];
  end
`else
  always_comb begin
    w_res_ov = 1'b0;
    w_res    = quo_d[W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      ov_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (B == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              q_q     <= '1;
              ov_q    <= 1'b0;
              dz_q    <= 1'b1;
            end else begin
              state_q <= S_DIV;
              b_q     <= B;
              d_q     <= (W+F)'(A) << F;
              r_q     <= '0;
              quo_q   <= '0;
              cnt_q   <= '0;
            end
          end
        end
        S_DIV: begin
          r_q   <= r_d;
          d_q   <= {d_q[W+F-2:0], 1'b0};
          quo_q <= quo_d[c_qw-2:0];
          cnt_q <= cnt_q + 1'b1;
          // A one among the top F quotient bits cannot fit in W bits.
          if (w_bit && (cnt_q < c_frac)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            q_q     <= '1;
            ov_q    <= 1'b1;
            dz_q    <= 1'b0;
          end else if (cnt_q == c_last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            q_q     <= w_res;
            ov_q    <= w_res_ov;
            dz_q    <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign ov   = ov_q;
  assign dz   = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_fxp_div_seq.sv
`default_nettype none
// tb_fxp_div_seq: directed vector table plus handshake corner cases for fxp_div_seq (W=10, F=4).
module tb_fxp_div_seq;

`ifdef FXDIV_ROUND_EN
  localparam int N = 15;
`else
  localparam int N = 14;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] A = '0;
  logic [9:0] B = '0;
  logic       busy, done, ov, dz;
  logic [9:0] q;

  int n_pass = 0;
  int n_total = 0;

  fxp_div_seq #(.W(10), .F(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .q(q), .ov(ov), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] eq;
    logic       eov;
    logic       edz;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Wait (bounded) for done, counting negedges after the accepting edge.
  task automatic wait_done(input string name, inout int k, output bit seen);
    seen = 1'b0;
    while (!seen && k < 60) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk({name, "_timeout"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic run(input string name, input logic [9:0] a, input logic [9:0] b,
                     input logic [9:0] eq, input logic eov, input logic edz, input int elat);
    int k;
    bit seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = '0; B = '0;
    k = 0;
    wait_done(name, k, seen);
    if (seen) begin
      chk({name, "_q"}, {22'd0, q}, {22'd0, eq});
      chk({name, "_ov"}, {31'd0, ov}, {31'd0, eov});
      chk({name, "_dz"}, {31'd0, dz}, {31'd0, edz});
      if (elat >= 0) chk({name, "_lat"}, k, elat);
      @(negedge clk);
      chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({name, "_idle"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int k;
    bit seen;
    logic [9:0] ra, rb, rq;
    logic rov;
    int t;

`ifdef FXDIV_ROUND_EN
    vecs[0]  = '{10'h030, 10'h018, 10'h020, 1'b0, 1'b0, N};
    vecs[1]  = '{10'h020, 10'h030, 10'h00B, 1'b0, 1'b0, N};
    vecs[7]  = '{10'h1FF, 10'h008, 10'h3FE, 1'b0, 1'b0, N};
    vecs[10] = '{10'h3FF, 10'h200, 10'h020, 1'b0, 1'b0, N};
`else
    vecs[0]  = '{10'h030, 10'h018, 10'h020, 1'b0, 1'b0, N};
    vecs[1]  = '{10'h020, 10'h030, 10'h00A, 1'b0, 1'b0, N};
    vecs[7]  = '{10'h1FF, 10'h008, 10'h3FE, 1'b0, 1'b0, N};
    vecs[10] = '{10'h3FF, 10'h200, 10'h01F, 1'b0, 1'b0, N};
`endif
    vecs[2]  = '{10'h3FF, 10'h008, 10'h3FF, 1'b1, 1'b0, 4};
    vecs[3]  = '{10'h050, 10'h000, 10'h3FF, 1'b0, 1'b1, 0};
    vecs[4]  = '{10'h010, 10'h010, 10'h010, 1'b0, 1'b0, N};
    vecs[5]  = '{10'h3FF, 10'h3FF, 10'h010, 1'b0, 1'b0, N};
    vecs[6]  = '{10'h001, 10'h3FF, 10'h000, 1'b0, 1'b0, N};
    vecs[8]  = '{10'h200, 10'h008, 10'h3FF, 1'b1, 1'b0, 4};
    vecs[9]  = '{10'h080, 10'h001, 10'h3FF, 1'b1, 1'b0, 3};
    vecs[11] = '{10'h000, 10'h005, 10'h000, 1'b0, 1'b0, N};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", {22'd0, q}, 32'd0);
    chk("rst_ov", {31'd0, ov}, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);

    for (int i = 0; i < 12; i++)
      run($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].eov, vecs[i].edz, vecs[i].lat);

    // Second start mid-division must be ignored.
    @(negedge clk);
    A = 10'h030; B = 10'h018; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = '0; B = '0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    A = 10'h3FF; B = 10'h008; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 4;
    wait_done("ignore", k, seen);
    if (seen) begin
      chk("ignore_q", {22'd0, q}, 32'h020);
      chk("ignore_ov", {31'd0, ov}, 32'd0);
      chk("ignore_lat", k, N);
    end
    @(negedge clk);

    // Reset mid-division, with a competing start on the reset edge.
    @(negedge clk);
    A = 10'h020; B = 10'h030; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; start = 1'b1; A = 10'h3FF; B = 10'h000;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_q", {22'd0, q}, 32'd0);
    chk("midrst_ov", {31'd0, ov}, 32'd0);
    chk("midrst_dz", {31'd0, dz}, 32'd0);
    @(negedge clk);
    chk("midrst_start_ignored", {31'd0, busy}, 32'd0);
    run("fresh", 10'h010, 10'h010, 10'h010, 1'b0, 1'b0, N);

    // Start held high: back-to-back operations.
    @(negedge clk);
    A = 10'h030; B = 10'h018; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    wait_done("b2b_first", k, seen);
    if (seen) begin
      chk("b2b_first_q", {22'd0, q}, 32'h020);
      chk("b2b_first_lat", k, N);
      A = 10'h0FF; B = 10'h010;
      @(negedge clk);
      k++;
      wait_done("b2b_second", k, seen);
      if (seen) begin
        chk("b2b_second_q", {22'd0, q}, 32'h0FF);
        chk("b2b_second_lat", k, 2 * N + 2);
      end
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Random sweep against an arithmetic reference.
    for (int i = 0; i < 150; i++) begin
      ra = 10'($urandom_range(1023, 0));
      rb = 10'($urandom_range(1023, 1));
`ifdef FXDIV_ROUND_EN
      t = (int'(ra) * 32) / int'(rb);
      t = (t >> 1) + (t & 1);
`else
      t = (int'(ra) * 16) / int'(rb);
`endif
      rov = (t >= 1024);
      rq  = rov ? 10'h3FF : 10'(t);
      run($sformatf("rnd%0d", i), ra, rb, rq, rov, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
